// File: rtl/proc_sequencer_pkg.sv
// Shared types and constants for the processor sequencer: opcodes, instruction
// field layout and the sequencer FSM state encoding.
package proc_pkg;

  localparam logic [2:0] OP_ALU0  = 3'b000;
  localparam logic [2:0] OP_ALU1  = 3'b001;
  localparam logic [2:0] OP_ALU2  = 3'b010;
  localparam logic [2:0] OP_ALU3  = 3'b011;
  localparam logic [2:0] OP_WRITE = 3'b100;

  localparam int unsigned INSTR_W = 11;
  localparam int unsigned RES_W   = 7;

  localparam int unsigned OPC_MSB  = 10;
  localparam int unsigned OPC_LSB  = 8;
  localparam int unsigned INP1_MSB = 7;
  localparam int unsigned INP1_LSB = 4;
  localparam int unsigned INP2_MSB = 3;
  localparam int unsigned INP2_LSB = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StFinish
  } seq_state_e;

endpackage

// File: rtl/proc_sequencer_if.sv
// Issue/result bus between the sequencer (master) and the 4-bit processor (slave).
interface proc_sequencer_if;
  logic [2:0] opcode_o;
  logic [3:0] inp1_o;
  logic [3:0] inp2_o;
  logic       reg_w_enable_o;
  logic [3:0] result_i;
  logic       sf_i;
  logic       zf_i;
  logic       cf_i;
  logic       invalid_op_i;

  modport master (
    output opcode_o, inp1_o, inp2_o, reg_w_enable_o,
    input  result_i, sf_i, zf_i, cf_i, invalid_op_i
  );

  modport slave (
    input  opcode_o, inp1_o, inp2_o, reg_w_enable_o,
    output result_i, sf_i, zf_i, cf_i, invalid_op_i
  );
endinterface

// File: rtl/proc_sequencer_ram.sv
// Single write port, asynchronous read memory; used for both program and result stores.
module seq_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  parameter int unsigned Aw    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/proc_sequencer.sv
// Issues a stored program to the 4-bit processor, two cycles per instruction,
// and records each result with its flags for host readback.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic [AW:0]        len,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [AW-1:0]      err_pc,
  proc_sequencer_if.master   proc,
  input  logic [AW-1:0]      rd_addr,
  output logic [RES_W-1:0]   rd_data
);

  seq_state_e state_q, state_d;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic          error_q, error_d;
  logic [AW-1:0] err_pc_q, err_pc_d;
  logic [2:0]    opcode_q, opcode_d;
  logic [3:0]    inp1_q, inp1_d;
  logic [3:0]    inp2_q, inp2_d;
  logic          wen_q, wen_d;

  logic               prog_wr;
  logic               last;
  logic               fetch_hit;
  logic [INSTR_W-1:0] prog_rdata;
  logic [INSTR_W-1:0] fetch_instr;
  logic               res_we;
  logic [RES_W-1:0]   res_wdata;

  assign prog_wr = prog_we && (state_q == StIdle);
  assign last    = ({1'b0, pc_q} == (len_q - (AW + 1)'(1)));

  // The program store is read at the next pc so the issue registers load on the
  // edge entering StIssue; a same-cycle write to that entry is forwarded.
  assign fetch_hit   = prog_wr && (prog_addr == pc_d);
  assign fetch_instr = fetch_hit ? prog_data : prog_rdata;

  assign res_we    = (state_q == StCapture);
  assign res_wdata = {proc.sf_i, proc.zf_i, proc.cf_i, proc.result_i};

  seq_ram #(
    .Width (INSTR_W),
    .Depth (DEPTH),
    .Aw    (AW)
  ) u_prog_ram (
    .clk_i   (clk),
    .we_i    (prog_wr),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_d),
    .rdata_o (prog_rdata)
  );

  seq_ram #(
    .Width (RES_W),
    .Depth (DEPTH),
    .Aw    (AW)
  ) u_res_ram (
    .clk_i   (clk),
    .we_i    (res_we),
    .waddr_i (pc_q),
    .wdata_i (res_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    error_d  = error_q;
    err_pc_d = err_pc_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len;
          error_d = 1'b0;
          pc_d    = '0;
          state_d = (len == '0) ? StFinish : StIssue;
        end
      end
      StIssue: begin
        if (proc.invalid_op_i) begin
          error_d  = 1'b1;
          err_pc_d = pc_q;
          state_d  = StFinish;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (last) begin
          state_d = StFinish;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = StIssue;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StFinish);
  end

  // Issue registers change only on entry to StIssue and hold through StCapture.
  always_comb begin
    opcode_d = opcode_q;
    inp1_d   = inp1_q;
    inp2_d   = inp2_q;
    wen_d    = 1'b0;
    if (state_d == StIssue) begin
      opcode_d = fetch_instr[OPC_MSB:OPC_LSB];
      inp1_d   = fetch_instr[INP1_MSB:INP1_LSB];
      inp2_d   = fetch_instr[INP2_MSB:INP2_LSB];
      wen_d    = (fetch_instr[OPC_MSB:OPC_LSB] == OP_WRITE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      len_q    <= '0;
      error_q  <= 1'b0;
      err_pc_q <= '0;
      opcode_q <= '0;
      inp1_q   <= '0;
      inp2_q   <= '0;
      wen_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      len_q    <= len_d;
      error_q  <= error_d;
      err_pc_q <= err_pc_d;
      opcode_q <= opcode_d;
      inp1_q   <= inp1_d;
      inp2_q   <= inp2_d;
      wen_q    <= wen_d;
    end
  end

  assign error               = error_q;
  assign err_pc              = err_pc_q;
  assign proc.opcode_o       = opcode_q;
  assign proc.inp1_o         = inp1_q;
  assign proc.inp2_o         = inp2_q;
  assign proc.reg_w_enable_o = wen_q;

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
- Drives the 4-bit processor datapath from the issuing side.
- Holds a small program of instructions, each {opcode, inp1, inp2}, and issues them in order to the processor.
- Captures each instruction's result and flags (SF/ZF/CF) into a readback buffer.
- Aborts with an error on an invalid opcode; a host loads the program, pulses start, then reads the results back.

Parameters:
- DEPTH, 16, number of program/result entries.
- AW, 4, address width; DEPTH = 2**AW.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- prog_we  in  1  program write strobe; ignored while busy.
- prog_addr  in  AW  program write address.
- prog_data  in  11  instruction {opcode[10:8], inp1[7:4], inp2[3:0]}.
- start  in  1  begin execution; ignored while busy.
- len  in  AW+1  number of instructions to run (0..DEPTH); latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at end of run (normal or error).
- error  out  1  sticky invalid-op flag for the last run; cleared on accepted start.
- err_pc  out  AW  index of the faulting instruction; valid while error=1.
- opcode_o  out  3  opcode to the processor.
- inp1_o  out  4  inp1 to the processor.
- inp2_o  out  4  inp2 to the processor.
- reg_w_enable_o  out  1  register-write enable to the processor.
- result_i  in  4  processor ALU result.
- sf_i, zf_i, cf_i  in  1 each  processor flags.
- invalid_op_i  in  1  processor invalid-opcode indication (combinational from opcode_o).
- rd_addr  in  AW  result readback address.
- rd_data  out  7  {sf, zf, cf, result[3:0]}; combinational read of the result buffer.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - busy, done, error, reg_w_enable_o = 0; err_pc = 0; opcode_o, inp1_o, inp2_o = 0; pc = 0.
  - Program and result memories are not reset.
- FSM states: IDLE, ISSUE, CAPTURE, FINISH.
- IDLE:
  - start=1 latches len, clears error, sets pc=0.
  - len=0 goes to FINISH; otherwise goes to ISSUE.
  - prog_we writes prog_mem[prog_addr] in IDLE only.
- ISSUE:
  - Drive opcode_o/inp1_o/inp2_o from prog_mem[pc], all registered and valid for this whole cycle.
  - reg_w_enable_o = 1 only in this cycle, and only if opcode == 3'b100.
  - If invalid_op_i = 1: error <= 1, err_pc <= pc, go to FINISH; no result is written.
  - Otherwise go to CAPTURE.
- CAPTURE:
  - The processor ALU is clocked, so result and flags are valid one cycle after issue.
  - Write {sf_i, zf_i, cf_i, result_i} to res_mem[pc], including for opcode 3'b100.
  - If pc == len-1, go to FINISH; else pc <= pc+1 and go to ISSUE.
  - reg_w_enable_o = 0; opcode/inp hold their ISSUE values.
- FINISH: done=1 for one cycle, then go to IDLE.
- Latency: 2 cycles per instruction. A run of N valid instructions asserts done at cycle 2N+1 after the start edge.
- len = DEPTH runs every entry; pc never wraps.
- start during busy is ignored, and len is not relatched.
- Simultaneous prog_we and start in IDLE: the write completes and the run starts; the written entry is visible at ISSUE.
- rd_addr is readable at any time. Reading the entry being written in CAPTURE returns the old value that cycle.
- Reset mid-run returns to IDLE immediately. Partial results remain in res_mem; error is cleared.

Decomposition:
- Shared package proc_pkg holds:
  - OP_WRITE = 3'b100 and OP_ALU0..OP_ALU3 = 3'b000..3'b011.
  - INSTR_W = 11 and RES_W = 7.
  - Field slice constants for opcode/inp1/inp2.
  - FSM state enum.
- One sub-module, seq_ram: a single-write-port, async-read memory, parameterised by width/depth. It is instantiated twice, once as the program store and once as the result store.

Test Plan:
- Reset mid-run: assert rst_n=0 during ISSUE of instruction 2 -> busy=0, reg_w_enable_o=0, opcode_o=0 asynchronously; a fresh start runs from pc=0.
- Write op: prog[0]={100,0011,0101}, len=1, start -> reg_w_enable_o=1 exactly one cycle with inp1_o=3, inp2_o=5; done pulses at cycle 3; error=0.
- Capture: processor stub returns result=inp1+inp2 (4-bit) and flags registered; prog[0..2]={000,1,2},{000,7,9},{001,4,4}, len=3 -> rd_data[0..2] equal the stub outputs, e.g. entry1 result=0 with CF=1, ZF=1; done at cycle 7.
- Invalid op: prog[0]={000,..}, prog[1]={111,..}, len=4 -> error=1, err_pc=1, done pulses; res_mem[1] unchanged; no ISSUE of entries 2 and 3.
- Boundaries: len=0 -> done the cycle after start with no issue; len=16 -> all 16 entries written and pc stops at 15; start pulsed while busy -> ignored, one done only.
- Program write during busy: prog_we to the next pc mid-run -> ignored, and the original instruction issues.
